// File: rtl/rr_grant_arbiter.sv
// Registered N-way arbiter: multi-hot request in, one-hot grant plus binary index out.
// Fixed-priority or round-robin selection, with optional hold until request release or acknowledge.

module rr_grant_arbiter_pe #(
  parameter int WIDTH    = 4,
  parameter int LSB_HIGH = 0,
  parameter int IDX_W    = 2
) (
  input  logic [WIDTH-1:0] vec,
  output logic             vld,
  output logic [IDX_W-1:0] idx,
  output logic [WIDTH-1:0] oh
);

  // The last assignment in scan order wins, so scan from lowest to highest priority.
  always_comb begin
    vld = |vec;
    idx = '0;
    oh  = '0;
    if (LSB_HIGH != 0) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (vec[i]) begin
          idx   = IDX_W'(i);
          oh    = '0;
          oh[i] = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (vec[i]) begin
          idx   = IDX_W'(i);
          oh    = '0;
          oh[i] = 1'b1;
        end
      end
    end
  end

endmodule

module rr_grant_arbiter #(
  parameter int PORTS                 = 4,
  parameter int ARB_TYPE_ROUND_ROBIN  = 1,
  parameter int ARB_BLOCK             = 1,
  parameter int ARB_BLOCK_ACK         = 1,
  parameter int ARB_LSB_HIGH_PRIORITY = 0,
  localparam int IDX_W = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PORTS-1:0] request,
  input  logic [PORTS-1:0] acknowledge,
  output logic [PORTS-1:0] grant,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_encoded
);

  logic             enc_u_vld;
  logic [IDX_W-1:0] enc_u_idx;
  logic [PORTS-1:0] enc_u_oh;
  logic             enc_m_vld;
  logic [IDX_W-1:0] enc_m_idx;
  logic [PORTS-1:0] enc_m_oh;

  logic [PORTS-1:0] mask_p1;
  logic [PORTS-1:0] gnt_p1;
  logic [IDX_W-1:0] idx_p1;
  logic             vld_p1;

  logic             owner_req_p0;
  logic             owner_ack_p0;
  logic             hold_p0;
  logic             use_m_p0;
  logic             pick_vld_p0;
  logic [IDX_W-1:0] pick_idx_p0;
  logic [PORTS-1:0] pick_oh_p0;

  // Ports that outrank the last winner in the rotation: strictly on the lower-priority side of it.
  function automatic logic [PORTS-1:0] rr_mask(input logic [IDX_W-1:0] win);
    logic [PORTS-1:0] m;
    for (int i = 0; i < PORTS; i++) begin
      m[i] = (ARB_LSB_HIGH_PRIORITY != 0) ? (i > int'(win)) : (i < int'(win));
    end
    return m;
  endfunction

  rr_grant_arbiter_pe #(
    .WIDTH    (PORTS),
    .LSB_HIGH (ARB_LSB_HIGH_PRIORITY),
    .IDX_W    (IDX_W)
  ) u_enc_u (
    .vec (request),
    .vld (enc_u_vld),
    .idx (enc_u_idx),
    .oh  (enc_u_oh)
  );

  rr_grant_arbiter_pe #(
    .WIDTH    (PORTS),
    .LSB_HIGH (ARB_LSB_HIGH_PRIORITY),
    .IDX_W    (IDX_W)
  ) u_enc_m (
    .vec (request & mask_p1),
    .vld (enc_m_vld),
    .idx (enc_m_idx),
    .oh  (enc_m_oh)
  );

  // Stage p0: hold decision and winner selection from the registered grant.
  assign owner_req_p0 = |(request & gnt_p1);
  assign owner_ack_p0 = |(acknowledge & gnt_p1);

  always_comb begin
    hold_p0 = 1'b0;
    if (vld_p1 && (ARB_BLOCK != 0)) begin
      hold_p0 = (ARB_BLOCK_ACK != 0) ? !owner_ack_p0 : owner_req_p0;
    end
  end

  assign use_m_p0    = (ARB_TYPE_ROUND_ROBIN != 0) && enc_m_vld;
  assign pick_vld_p0 = use_m_p0 || enc_u_vld;
  assign pick_idx_p0 = use_m_p0 ? enc_m_idx : enc_u_idx;
  assign pick_oh_p0  = use_m_p0 ? enc_m_oh  : enc_u_oh;

  // Stage p1: registered grant and rotation mask.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_p1  <= '0;
      idx_p1  <= '0;
      vld_p1  <= 1'b0;
      mask_p1 <= '0;
    end else if (!hold_p0) begin
      gnt_p1 <= pick_oh_p0;
      idx_p1 <= pick_idx_p0;
      vld_p1 <= pick_vld_p0;
      if ((ARB_TYPE_ROUND_ROBIN != 0) && pick_vld_p0) begin
        mask_p1 <= rr_mask(pick_idx_p0);
      end
    end
  end

  assign grant         = gnt_p1;
  assign grant_valid   = vld_p1;
  assign grant_encoded = idx_p1;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Bench for rr_grant_arbiter: four configurations share one stimulus stream and are scored
// against a rotation-order reference model through an expected-response queue.

module tb_rr_grant_arbiter;

  localparam int P  = 4;
  localparam int ND = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic [P-1:0] request = '0;
  logic [P-1:0] acknowledge = '0;

  logic [P-1:0] gnt [ND];
  logic         gv  [ND];
  logic [1:0]   ge  [ND];

  // 0: round-robin + hold-until-ack, 1: fixed priority, 2: round-robin free, 3: round-robin hold-on-request
  bit cfg_rr  [ND] = '{1'b1, 1'b0, 1'b1, 1'b1};
  bit cfg_blk [ND] = '{1'b1, 1'b0, 1'b0, 1'b1};
  bit cfg_ack [ND] = '{1'b1, 1'b0, 1'b0, 1'b0};

  rr_grant_arbiter #(.PORTS(P), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(1), .ARB_BLOCK_ACK(1),
                     .ARB_LSB_HIGH_PRIORITY(0)) u_rr_ack (
    .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
    .grant(gnt[0]), .grant_valid(gv[0]), .grant_encoded(ge[0]));

  rr_grant_arbiter #(.PORTS(P), .ARB_TYPE_ROUND_ROBIN(0), .ARB_BLOCK(0), .ARB_BLOCK_ACK(0),
                     .ARB_LSB_HIGH_PRIORITY(0)) u_fixed (
    .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
    .grant(gnt[1]), .grant_valid(gv[1]), .grant_encoded(ge[1]));

  rr_grant_arbiter #(.PORTS(P), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(0), .ARB_BLOCK_ACK(0),
                     .ARB_LSB_HIGH_PRIORITY(0)) u_rr_free (
    .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
    .grant(gnt[2]), .grant_valid(gv[2]), .grant_encoded(ge[2]));

  rr_grant_arbiter #(.PORTS(P), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(1), .ARB_BLOCK_ACK(0),
                     .ARB_LSB_HIGH_PRIORITY(0)) u_rr_req (
    .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
    .grant(gnt[3]), .grant_valid(gv[3]), .grant_encoded(ge[3]));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input int d, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s dut%0d actual=%0h expected=%0h at %0t", nm, d, act, exp, $time);
    end
  endtask

  // Reference model: current owner, last round-robin winner, and whether a winner exists since reset.
  int m_cur  [ND];
  int m_last [ND];
  bit m_has  [ND];

  function automatic void model_step(input int d, input logic [P-1:0] r, input logic [P-1:0] a,
                                     input bit rs);
    int w;
    if (rs) begin
      m_cur[d] = -1;
      m_has[d] = 1'b0;
      return;
    end
    if (m_cur[d] >= 0 && cfg_blk[d]) begin
      if (!cfg_ack[d] && r[m_cur[d]]) return;
      if (cfg_ack[d] && !a[m_cur[d]]) return;
    end
    w = -1;
    if (cfg_rr[d] && m_has[d]) begin
      // Walk downward from just below the last winner, wrapping to the top.
      for (int k = 1; k <= P; k++) begin
        int j;
        j = (m_last[d] - k + P) % P;
        if (w < 0 && r[j]) w = j;
      end
    end else begin
      for (int j = P - 1; j >= 0; j--) if (w < 0 && r[j]) w = j;
    end
    m_cur[d] = w;
    if (w >= 0 && cfg_rr[d]) begin
      m_last[d] = w;
      m_has[d]  = 1'b1;
    end
  endfunction

  typedef struct packed {
    logic [ND-1:0][P-1:0] g;
    logic [ND-1:0][1:0]   e;
  } exp_t;

  exp_t exp_q[$];

  task automatic cyc(input logic [P-1:0] r, input logic [P-1:0] a, input bit rs);
    exp_t x;
    @(negedge clk);
    request     = r;
    acknowledge = a;
    rst         = rs;
    for (int d = 0; d < ND; d++) begin
      model_step(d, r, a, rs);
      x.g[d] = (m_cur[d] >= 0) ? P'(1 << m_cur[d]) : '0;
      x.e[d] = (m_cur[d] >= 0) ? 2'(m_cur[d]) : 2'd0;
    end
    exp_q.push_back(x);
    @(posedge clk);
    #2;
  endtask

  // Monitor: one expected entry per clock edge once stimulus has started.
  exp_t mx;
  int   waitc [ND][P];
  logic [P-1:0] prev_g [ND];

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mx = exp_q.pop_front();
      for (int d = 0; d < ND; d++) begin
        chk("grant", d, int'(gnt[d]), int'(mx.g[d]));
        chk("grant_valid", d, int'(gv[d]), int'(|mx.g[d]));
        chk("grant_encoded", d, int'(ge[d]), int'(mx.e[d]));
        chk("onehot0", d, int'($onehot0(gnt[d])), 1);
        chk("valid_or", d, int'(gv[d]), int'(|gnt[d]));
        if (gv[d]) chk("enc_match", d, int'(gnt[d]), int'(P'(1) << ge[d]));
        if (cfg_rr[d]) begin
          for (int j = 0; j < P; j++) begin
            if (rst || !request[j] || gnt[d][j]) begin
              waitc[d][j] = 0;
            end else if (gnt[d] != prev_g[d] && gnt[d] != '0) begin
              waitc[d][j] = waitc[d][j] + 1;
              chk("starvation", d, int'(waitc[d][j] > P), 0);
            end
          end
        end
        prev_g[d] = gnt[d];
      end
    end
  end

  logic [P-1:0] rr_seq [4];
  logic [P-1:0] rq;
  logic [P-1:0] ak;

  initial begin
    for (int d = 0; d < ND; d++) begin
      m_cur[d]  = -1;
      m_last[d] = 0;
      m_has[d]  = 1'b0;
      prev_g[d] = '0;
      for (int j = 0; j < P; j++) waitc[d][j] = 0;
    end

    // Reset with all requests high, then idle.
    repeat (2) begin
      cyc(4'b1111, 4'b0000, 1'b1);
      for (int d = 0; d < ND; d++) begin
        chk("rst_grant", d, int'(gnt[d]), 0);
        chk("rst_valid", d, int'(gv[d]), 0);
      end
    end
    cyc(4'b0000, 4'b0000, 1'b0);
    for (int d = 0; d < ND; d++) chk("idle_grant", d, int'(gnt[d]), 0);

    // Fixed priority: highest set bit wins every cycle.
    repeat (3) begin
      cyc(4'b0110, 4'b0000, 1'b0);
      chk("fixed_grant", 1, int'(gnt[1]), 4'b0100);
      chk("fixed_enc", 1, int'(ge[1]), 2);
    end

    // Round-robin rotation with a constant request pattern.
    cyc(4'b1111, 4'b0000, 1'b1);
    rr_seq = '{4'b1000, 4'b0010, 4'b0001, 4'b1000};
    for (int i = 0; i < 4; i++) begin
      cyc(4'b1011, 4'b0000, 1'b0);
      chk("rr_rotate", 2, int'(gnt[2]), int'(rr_seq[i]));
    end
    chk("rr_enc_wrap", 2, int'(ge[2]), 3);

    // Hold until acknowledge, then hand over without a bubble.
    cyc(4'b0000, 4'b0000, 1'b1);
    cyc(4'b0011, 4'b0000, 1'b0);
    chk("ack_first", 0, int'(gnt[0]), 4'b0010);
    repeat (5) begin
      cyc(4'b0001, 4'b0000, 1'b0);
      chk("ack_hold", 0, int'(gnt[0]), 4'b0010);
    end
    cyc(4'b0001, 4'b0010, 1'b0);
    chk("ack_handover", 0, int'(gnt[0]), 4'b0001);
    chk("ack_handover_enc", 0, int'(ge[0]), 0);

    // Hold while the owner keeps requesting; stray acknowledges do nothing.
    cyc(4'b0000, 4'b0000, 1'b1);
    cyc(4'b0110, 4'b0000, 1'b0);
    chk("req_first", 3, int'(gnt[3]), 4'b0100);
    repeat (2) begin
      cyc(4'b0110, 4'b1111, 1'b0);
      chk("req_hold", 3, int'(gnt[3]), 4'b0100);
    end
    cyc(4'b0010, 4'b1111, 1'b0);
    chk("req_release", 3, int'(gnt[3]), 4'b0010);

    // Reset while a grant is active.
    cyc(4'b0000, 4'b0000, 1'b1);
    cyc(4'b1000, 4'b0000, 1'b0);
    for (int d = 0; d < ND; d++) chk("pre_rst_grant", d, int'(gnt[d]), 4'b1000);
    cyc(4'b1000, 4'b0000, 1'b1);
    for (int d = 0; d < ND; d++) begin
      chk("midrst_grant", d, int'(gnt[d]), 0);
      chk("midrst_valid", d, int'(gv[d]), 0);
      chk("midrst_enc", d, int'(ge[d]), 0);
    end

    // Random soak: requests toggle sparsely so they persist across several grants.
    rq = '0;
    for (int n = 0; n < 10000; n++) begin
      rq = rq ^ (P'($urandom) & P'($urandom));
      ak = P'($urandom) & P'($urandom);
      cyc(rq, ak, 1'b0);
    end

    cyc(4'b0000, 4'b0000, 1'b0);
    @(posedge clk);
    #3;
    chk("queue_drain", 0, exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
